// File: rtl/muldiv_unit_if.sv
// Controller-side bus of the multiply/divide unit: launch handshake, HI/LO moves and HI/LO readback.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, mthi, mtlo, wdata,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, mthi, mtlo, wdata,
        output busy, done, divzero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 33-cycle multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide share one double-width accumulator.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_by_zero;
    logic [WIDTH-1:0]   r_operand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // op[0] marks the unsigned variants, op[1] marks divide.
    assign w_sign_a = ~bus.op[0] & bus.opa[WIDTH-1];
    assign w_sign_b = ~bus.op[0] & bus.opb[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -bus.opa : bus.opa;
    assign w_mag_b  = w_sign_b ? -bus.opb : bus.opb;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: each always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start)     w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == '0)   w_state_nxt = S_FIX;
            S_FIX:                      w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Multiply: acc = {partial, multiplier}, add-then-shift right.
    // Divide:   acc = {remainder, dividend/quotient}, shift left and trial-subtract.
    always_comb begin
        w_addend    = r_acc[0] ? r_operand : '0;
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_operand};
        w_acc_step  = {w_mul_sum, r_acc[WIDTH-1:1]};
        if (r_is_div) begin
            if (w_div_trial[WIDTH]) w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
            else                    w_acc_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_is_div      <= 1'b0;
            r_neg_res     <= 1'b0;
            r_neg_rem     <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_operand     <= '0;
            r_acc         <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_divzero     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt         <= CNT_W'(WIDTH - 1);
                        r_busy        <= 1'b1;
                        r_is_div      <= bus.op[1];
                        r_neg_res     <= w_sign_a ^ w_sign_b;
                        r_neg_rem     <= w_sign_a;
                        r_div_by_zero <= bus.op[1] && (bus.opb == '0);
                        r_operand     <= bus.op[1] ? w_mag_b : w_mag_a;
                        r_acc         <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
                    end else begin
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_div_by_zero) begin
                        // Remainder of a zero divisor is the dividend, restored to its raw value.
                        r_hi      <= w_rem_fix;
                        r_lo      <= '1;
                        r_divzero <= 1'b1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.divzero = r_divzero;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS core, directly downstream of the register file.
- Consumes the two register-file read operands on MULT/MULTU/DIV/DIVU and produces results into architectural HI/LO registers.
- HI/LO are read back combinationally for MFHI/MFLO and written directly for MTHI/MTLO.
- A start/busy/done handshake lets the controller stall dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa  input  WIDTH  rs operand (register-file regdat1).
- opb  input  WIDTH  rt operand (register-file regdat2).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated.
- divzero  output  1  pulses with done when a DIV/DIVU had opb=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, divzero=0; counter=0.
  - Any in-flight operation is aborted with no HI/LO update.
- States:
  - IDLE: start=1 at edge E0 latches op, |opa|, |opb| (magnitudes for signed ops, raw for unsigned) and result-sign flags, then goes to CALC with counter=31. busy=1 from E0 onward.
  - CALC: one iteration per edge; counter decrements; after the iteration with counter=0, goes to FIX. This is 32 edges, E1..E32.
  - FIX (E33): applies sign correction, writes hi/lo, pulses done=1 for one cycle, sets busy=0, returns to IDLE.
  - Start-to-done latency is exactly 33 cycles. A new start is accepted in the cycle done is high.
- Multiply:
  - Shift-add on a 64-bit product register.
  - {hi,lo} = full 64-bit product.
  - MULT negates the product if exactly one operand is negative.
- Divide:
  - Restoring, one quotient bit per iteration.
  - lo=quotient, hi=remainder.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, divzero=0.
- Divide by zero (opb=0, DIV or DIVU):
  - Still 33 cycles.
  - hi=opa (raw value), lo=0xFFFFFFFF.
  - divzero=1 in the done cycle.
- Illegal or ignored inputs:
  - start while busy=1 is ignored; the operands are not relatched.
  - mthi/mtlo while busy=1 are ignored.
  - mthi/mtlo in IDLE update hi/lo at the next edge.
  - start and mthi/mtlo in the same idle cycle: start wins and the move is dropped.
  - mthi and mtlo together both write wdata.
- Output timing:
  - hi/lo hold their previous values throughout CALC and change only at FIX or on an idle move.
  - done and divzero are low in every cycle except the FIX-output cycle.
- Operands are sampled only at E0, so changes on opa/opb during busy have no effect.

Test Plan:
- Reset, then MULTU opa=0xFFFFFFFF, opb=0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT opa=0xFFFFFFFD (-3), opb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Same inputs with MULTU -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU opa=100, opb=7 -> lo=14, hi=2.
- DIVU opa=0x1234, opb=0 -> after 33 cycles: hi=0x1234, lo=0xFFFFFFFF, divzero=1 for one cycle. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 5x6 started, then at cycle 10 assert start with different operands, mthi=1, and change opa -> all ignored; result hi=0, lo=30 at cycle 33. Then mtlo wdata=0xABCD in idle -> lo=0xABCD at next edge; start+mthi together -> hi not written by the move.
- Start DIVU, assert rst at cycle 15 -> busy, done, hi, lo immediately 0; no done pulse afterward. Back-to-back start in the done cycle -> second result after a further 33 cycles.
